soc_pmem_arbiter: RTL and testbench
===================================

Name: soc_pmem_arbiter

Overview:
Arbitrates two bus masters onto port B of the dual-port program-memory RAM (soc_ram_p2); port A stays dedicated to the CPU fetch path. Master 0 is the debug interface and master 1 is the DMA/loader. The block uses round-robin arbitration with a bounded burst length, drives the RAM port B controls (enable, byte write enables, address, data), and routes the one-cycle-latency read data back to the master that issued the read, with a valid pulse.

Parameters:
ADDR_MSB, `PMEM_MSB, MSB of the word address on masters and RAM.
BURST_MAX, 4, maximum consecutive granted cycles for one master while the other requests (range 1..16).
CNT_W, $clog2(BURST_MAX)+1, burst counter width (local, derived).

Ports:
mclk  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
m0_req  input  1  master 0 access request
m0_we  input  2  master 0 byte write enables; 2'b00 means read
m0_addr  input  ADDR_MSB+1  master 0 word address
m0_din  input  16  master 0 write data
m0_gnt  output  1  master 0 grant; combinational, same cycle as request
m0_rdata  output  16  master 0 read data; valid when m0_rvalid=1
m0_rvalid  output  1  master 0 read data valid (1-cycle pulse)
m1_req, m1_we, m1_addr, m1_din, m1_gnt, m1_rdata, m1_rvalid  (same as master 0, for master 1)
ram_en  output  1  RAM port B enable, active high
ram_we  output  2  RAM port B byte write enables
ram_addr  output  ADDR_MSB+1  RAM port B address
ram_din  output  16  RAM port B write data
ram_dout  input  16  RAM port B read data, registered by RAM, 1-cycle latency

Behaviour:
- Registered state: owner {NONE, M0, M1}, last_winner (1 bit), burst_cnt (CNT_W bits), rd_pend0, rd_pend1.
- Reset (async, reset_n=0): owner=NONE, last_winner=1 (master 0 wins the first contention), burst_cnt=0, rd_pend*=0. All outputs are 0 during reset: gnt, rvalid, ram_en, ram_we, ram_addr, ram_din; rdata driven to 0 while rvalid=0.
- Winner selection is combinational each cycle:
  - Neither master requests -> no winner.
  - Only one master requests -> that master wins.
  - Both request, owner=Mx, and burst_cnt<BURST_MAX-1 -> Mx keeps the grant.
  - Both request, owner=Mx, and burst_cnt==BURST_MAX-1 -> the other master wins.
  - Both request and owner=NONE -> the master that is not last_winner wins.
- Outputs for the winner W: mW_gnt=1 and the other gnt=0. ram_en=1, ram_we=mW_we, ram_addr=mW_addr, ram_din=mW_din. With no winner, ram_en=0 and ram_we=0; addr/din are 0.
- A transfer is accepted on the clock edge where req&gnt=1. There is no wait state, so a master holding req high is served every cycle it wins.
- Next-state update:
  - owner<=W, or NONE if no winner.
  - last_winner<=W when there is a winner, otherwise held.
  - burst_cnt<=0 when W differs from the current owner (new grant), or when there is no winner.
  - burst_cnt<=min(burst_cnt+1, BURST_MAX-1) when W equals the owner.
- Read return:
  - rd_pendW<=1 on an accepted read (we==2'b00).
  - The next cycle, mW_rvalid=rd_pendW and mW_rdata=ram_dout (gated to 0 when not valid).
  - Writes produce no rvalid.
  - Back-to-back reads give rvalid high on consecutive cycles, each carrying the data of the previous cycle's address.
- Partial writes: ram_we=2'b01 writes the low byte only and 2'b10 the high byte only. The arbiter passes byte enables unmodified.
- Simultaneous read return and new grant to the other master: both complete in the same cycle, because rvalid depends only on rd_pend.
- A master may drop req at any time. The ungranted master's inputs are ignored.
- With BURST_MAX=1, ownership strictly alternates under contention.
- Reset asserted mid-burst or with a read pending: state clears immediately and the pending rvalid is lost (no pulse after reset release).
- The block never asserts both gnt signals at once and never asserts ram_en without a gnt.

Test Plan:
- Reset: hold reset_n=0 with both req=1 -> all gnt, rvalid and ram_en are 0; first cycle after release -> m0_gnt=1.
- Single master write then read: m1 writes 16'hA55A at addr 5 (we=11), next cycle reads addr 5 -> ram_en=1 both cycles; m1_rvalid=1 one cycle after the read with m1_rdata=16'hA55A; m0_rvalid stays 0.
- Contention burst, BURST_MAX=4, both req held for 12 cycles -> grant pattern M0 x4, M1 x4, M0 x4; never both gnt=1.
- Byte write: write 16'h1234 to addr 9, then write we=2'b10 with din 16'hABCD, then read -> rdata=16'hAB34.
- Interleaved reads: m0 reads addr 1 (16'h0001) at cycle N, m1 reads addr 2 (16'h0002) at cycle N+1 -> m0_rvalid at N+1 with 16'h0001, m1_rvalid at N+2 with 16'h0002.
- Reset mid-operation: assert reset_n=0 in the cycle after an accepted m0 read -> m0_rvalid=0; after release, owner=NONE and the next contention grants m0.

Source files
------------

// File: rtl/soc_pmem_arbiter.sv
// Two-master round-robin arbiter for program-memory RAM port B.
// Master 0 is debug and master 1 is DMA/loader. Bursts are bounded, and read data returns with a one-cycle valid pulse.
`ifndef PMEM_MSB
`define PMEM_MSB 11
`endif

module soc_pmem_arbiter #(
  parameter int ADDR_MSB  = `PMEM_MSB,
  parameter int BURST_MAX = 4
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic [1:0]        m0_we,
  input  logic [ADDR_MSB:0] m0_addr,
  input  logic [15:0]       m0_din,
  output logic              m0_gnt,
  output logic [15:0]       m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic [1:0]        m1_we,
  input  logic [ADDR_MSB:0] m1_addr,
  input  logic [15:0]       m1_din,
  output logic              m1_gnt,
  output logic [15:0]       m1_rdata,
  output logic              m1_rvalid,
  output logic              ram_en,
  output logic [1:0]        ram_we,
  output logic [ADDR_MSB:0] ram_addr,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout
);

  localparam int CNT_W = $clog2(BURST_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_e;

  owner_e             owner_r, owner_n_s, win_owner_s;
  logic               last_winner_r, last_winner_n_s;
  logic [CNT_W-1:0]   burst_cnt_r, burst_cnt_n_s;
  logic               rd_pend0_r, rd_pend1_r, rd_pend0_n_s, rd_pend1_n_s;
  logic               win_vld_s, win_sel_s;

  // Winner selection; reset gating keeps grants low while reset_n is asserted
  always_comb begin
    win_vld_s = 1'b0;
    win_sel_s = 1'b0;
    if (!reset_n) begin
      win_vld_s = 1'b0;
      win_sel_s = 1'b0;
    end else if (m0_req && m1_req) begin
      win_vld_s = 1'b1;
      case (owner_r)
        OWN_M0:  win_sel_s = (burst_cnt_r < CNT_LAST) ? 1'b0 : 1'b1;
        OWN_M1:  win_sel_s = (burst_cnt_r < CNT_LAST) ? 1'b1 : 1'b0;
        default: win_sel_s = ~last_winner_r;
      endcase
    end else if (m0_req) begin
      win_vld_s = 1'b1;
      win_sel_s = 1'b0;
    end else if (m1_req) begin
      win_vld_s = 1'b1;
      win_sel_s = 1'b1;
    end else begin
      win_vld_s = 1'b0;
      win_sel_s = 1'b0;
    end
  end

  // Next-state computation for ownership, burst length and pending reads
  always_comb begin
    win_owner_s     = OWN_NONE;
    owner_n_s       = OWN_NONE;
    last_winner_n_s = last_winner_r;
    burst_cnt_n_s   = {CNT_W{1'b0}};
    if (win_vld_s) begin
      win_owner_s     = win_sel_s ? OWN_M1 : OWN_M0;
      owner_n_s       = win_owner_s;
      last_winner_n_s = win_sel_s;
      if (win_owner_s == owner_r) begin
        burst_cnt_n_s = (burst_cnt_r == CNT_LAST) ? burst_cnt_r : burst_cnt_r + CNT_W'(1);
      end else begin
        burst_cnt_n_s = {CNT_W{1'b0}};
      end
    end else begin
      win_owner_s     = OWN_NONE;
      owner_n_s       = OWN_NONE;
      last_winner_n_s = last_winner_r;
      burst_cnt_n_s   = {CNT_W{1'b0}};
    end
    rd_pend0_n_s = win_vld_s && !win_sel_s && (m0_we == 2'b00);
    rd_pend1_n_s = win_vld_s &&  win_sel_s && (m1_we == 2'b00);
  end

  // Arbiter state registers
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      owner_r       <= OWN_NONE;
      last_winner_r <= 1'b1;
      burst_cnt_r   <= {CNT_W{1'b0}};
      rd_pend0_r    <= 1'b0;
      rd_pend1_r    <= 1'b0;
    end else begin
      owner_r       <= owner_n_s;
      last_winner_r <= last_winner_n_s;
      burst_cnt_r   <= burst_cnt_n_s;
      rd_pend0_r    <= rd_pend0_n_s;
      rd_pend1_r    <= rd_pend1_n_s;
    end
  end

  // Grant and RAM port B drive from the current winner
  always_comb begin
    m0_gnt   = win_vld_s & ~win_sel_s;
    m1_gnt   = win_vld_s &  win_sel_s;
    ram_en   = 1'b0;
    ram_we   = 2'b00;
    ram_addr = {(ADDR_MSB+1){1'b0}};
    ram_din  = 16'h0000;
    if (win_vld_s) begin
      ram_en   = 1'b1;
      ram_we   = win_sel_s ? m1_we   : m0_we;
      ram_addr = win_sel_s ? m1_addr : m0_addr;
      ram_din  = win_sel_s ? m1_din  : m0_din;
    end else begin
      ram_en   = 1'b0;
    end
  end

  // Read return; data is gated so idle masters see zero
  always_comb begin
    m0_rvalid = rd_pend0_r;
    m1_rvalid = rd_pend1_r;
    if (rd_pend0_r) m0_rdata = ram_dout;
    else            m0_rdata = 16'h0000;
    if (rd_pend1_r) m1_rdata = ram_dout;
    else            m1_rdata = 16'h0000;
  end

endmodule

// File: tb/tb_soc_pmem_arbiter.sv
// Self-checking bench for soc_pmem_arbiter: directed plan steps plus random traffic
// against a run-length based reference model and a reference memory image.
module tb_soc_pmem_arbiter;

  localparam int AW = 12;
  localparam int BMAX = 4;

  logic          mclk = 1'b0;
  logic          reset_n;
  logic          m0_req, m1_req;
  logic [1:0]    m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [15:0]   m0_din, m1_din;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0]   m0_rdata, m1_rdata;
  logic          ram_en;
  logic [1:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din, ram_dout;

  logic [15:0] ram_mem [0:(1<<AW)-1];
  logic [15:0] ref_mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: owner as master index (-1 none), consecutive-grant run length
  int m_owner, m_run, m_last;
  logic m_p0, m_p1;
  logic [15:0] m_d0, m_d1;

  always #5 mclk = ~mclk;

  soc_pmem_arbiter #(.ADDR_MSB(AW-1), .BURST_MAX(BMAX)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Port B of the RAM: byte writes, registered read data
  always @(posedge mclk) begin
    if (ram_en) begin
      if (ram_we[0]) ram_mem[ram_addr][7:0]  <= ram_din[7:0];
      if (ram_we[1]) ram_mem[ram_addr][15:8] <= ram_din[15:8];
      ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic r0, input logic [1:0] w0,
                      input logic [AW-1:0] a0, input logic [15:0] d0,
                      input logic r1, input logic [1:0] w1,
                      input logic [AW-1:0] a1, input logic [15:0] d1);
    int w;
    logic [1:0] ewe;
    logic [AW-1:0] ea;
    logic [15:0] ed;
    @(negedge mclk);
    reset_n = rst; m0_req = r0; m0_we = w0; m0_addr = a0; m0_din = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_din = d1;
    #1;
    if (!rst) begin
      m_owner = -1; m_run = 0; m_last = 1; m_p0 = 1'b0; m_p1 = 1'b0;
    end
    // Who should win this cycle
    w = -1;
    if (rst) begin
      if (r0 && r1) begin
        if (m_owner >= 0) w = (m_run < BMAX) ? m_owner : 1 - m_owner;
        else              w = 1 - m_last;
      end else if (r0) w = 0;
      else if (r1) w = 1;
    end
    ewe = (w == 0) ? w0 : (w == 1) ? w1 : 2'b00;
    ea  = (w == 0) ? a0 : (w == 1) ? a1 : '0;
    ed  = (w == 0) ? d0 : (w == 1) ? d1 : 16'h0000;
    chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
    chk("gnt_excl", 32'(m0_gnt & m1_gnt), 32'd0);
    chk("ram_en", 32'(ram_en), 32'(w >= 0));
    chk("ram_we", 32'(ram_we), 32'(ewe));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    chk("ram_din", 32'(ram_din), 32'(ed));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(m_p0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(m_p1));
    chk("m0_rdata", 32'(m0_rdata), m_p0 ? 32'(m_d0) : 32'd0);
    chk("m1_rdata", 32'(m1_rdata), m_p1 ? 32'(m_d1) : 32'd0);
    // Advance the model to the state after the coming edge
    m_p0 = 1'b0; m_p1 = 1'b0;
    if (rst) begin
      if (w >= 0) begin
        m_run   = (w == m_owner) ? m_run + 1 : 1;
        m_owner = w;
        m_last  = w;
        if (ewe == 2'b00) begin
          if (w == 0) begin m_p0 = 1'b1; m_d0 = ref_mem[ea]; end
          else        begin m_p1 = 1'b1; m_d1 = ref_mem[ea]; end
        end else begin
          if (ewe[0]) ref_mem[ea][7:0]  = ed[7:0];
          if (ewe[1]) ref_mem[ea][15:8] = ed[15:8];
        end
      end else begin
        m_owner = -1; m_run = 0;
      end
    end
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 2'b00, '0, 16'h0000, 1'b0, 2'b00, '0, 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    ram_dout = 16'h0000;
    m_owner = -1; m_run = 0; m_last = 1; m_p0 = 1'b0; m_p1 = 1'b0;
    m_d0 = 16'h0000; m_d1 = 16'h0000;
    reset_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 2'b00; m1_we = 2'b00;
    m0_addr = '0; m1_addr = '0; m0_din = 16'h0000; m1_din = 16'h0000;

    // Reset held with both masters requesting
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 2'b00, 12'd0, 16'h0000, 1'b1, 2'b00, 12'd0, 16'h0000);

    // Contention right after release: M0 x4, M1 x4, M0 x4
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 2'b00, 12'(i), 16'h0000, 1'b1, 2'b00, 12'(i + 100), 16'h0000);
      chk("burst_pattern", 32'(m0_gnt), 32'(((i / BMAX) % 2) == 0));
    end
    idle(1'b1);

    // Master 1 write then read of address 5
    step(1'b1, 1'b0, 2'b00, 12'd0, 16'h0000, 1'b1, 2'b11, 12'd5, 16'hA55A);
    step(1'b1, 1'b0, 2'b00, 12'd0, 16'h0000, 1'b1, 2'b00, 12'd5, 16'h0000);
    idle(1'b1);
    chk("m1_read_valid", 32'(m1_rvalid), 32'd1);
    chk("m1_read_data", 32'(m1_rdata), 32'hA55A);
    chk("m0_no_valid", 32'(m0_rvalid), 32'd0);

    // High-byte partial write
    step(1'b1, 1'b1, 2'b11, 12'd9, 16'h1234, 1'b0, 2'b00, 12'd0, 16'h0000);
    step(1'b1, 1'b1, 2'b10, 12'd9, 16'hABCD, 1'b0, 2'b00, 12'd0, 16'h0000);
    step(1'b1, 1'b1, 2'b00, 12'd9, 16'h0000, 1'b0, 2'b00, 12'd0, 16'h0000);
    idle(1'b1);
    chk("byte_write_data", 32'(m0_rdata), 32'hAB34);

    // Interleaved reads from the two masters
    step(1'b1, 1'b1, 2'b11, 12'd1, 16'h0001, 1'b0, 2'b00, 12'd0, 16'h0000);
    step(1'b1, 1'b0, 2'b00, 12'd0, 16'h0000, 1'b1, 2'b11, 12'd2, 16'h0002);
    step(1'b1, 1'b1, 2'b00, 12'd1, 16'h0000, 1'b0, 2'b00, 12'd0, 16'h0000);
    step(1'b1, 1'b0, 2'b00, 12'd0, 16'h0000, 1'b1, 2'b00, 12'd2, 16'h0000);
    chk("ilv_m0_valid", 32'(m0_rvalid), 32'd1);
    chk("ilv_m0_data", 32'(m0_rdata), 32'h0001);
    idle(1'b1);
    chk("ilv_m1_valid", 32'(m1_rvalid), 32'd1);
    chk("ilv_m1_data", 32'(m1_rdata), 32'h0002);

    // Reset right after an accepted read drops the pending return
    step(1'b1, 1'b1, 2'b00, 12'd1, 16'h0000, 1'b0, 2'b00, 12'd0, 16'h0000);
    idle(1'b0);
    chk("rst_drops_rvalid", 32'(m0_rvalid), 32'd0);
    idle(1'b0);
    step(1'b1, 1'b1, 2'b00, 12'd3, 16'h0000, 1'b1, 2'b00, 12'd4, 16'h0000);
    chk("post_rst_m0_wins", 32'(m0_gnt), 32'd1);
    idle(1'b1);

    // Random traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      step(1'b1,
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 12'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 12'($urandom_range(0, 15)), 16'($urandom));
    end
    idle(1'b1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
